prog_timer: RTL and testbench

PROG_TIMER -- requirements
Module: prog_timer

---
 rtl/prog_timer_if.sv | 36 +++
 rtl/prog_timer.sv | 127 ++++++++++++
 tb/tb_prog_timer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/prog_timer_if.sv
// ----------------------------------------------------------------------------
// Module      : prog_timer_if
// Description : Control/status bundle for the programmable timer.
//               master : en, start, stop, load, load_val, dir, mode -> timer
//               slave  : cnt, tick, tc, busy                        <- timer
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface prog_timer_if #(
  parameter int WIDTH = 10
);
  logic             en;
  logic             start;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic             mode;
  logic [WIDTH-1:0] cnt;
  logic             tick;
  logic             tc;
  logic             busy;

  modport master (
    output en, start, stop, load, load_val, dir, mode,
    input  cnt, tick, tc, busy
  );

  modport slave (
    input  en, start, stop, load, load_val, dir, mode,
    output cnt, tick, tc, busy
  );
endinterface

`default_nettype wire

// File: rtl/prog_timer.sv
// ----------------------------------------------------------------------------
// Module      : prog_timer
// Description : Programmable up/down timer with prescaler, periodic or
//               one-shot run mode and synchronous load.
//   clk  : clock, rising edge active
//   rst  : asynchronous active-high reset
//   bus  : prog_timer_if.slave
//            en/start/stop/load/load_val/dir/mode in
//            cnt/tick/tc/busy out (cnt/tick/tc registered)
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module prog_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int WIDTH    = 10
) (
  input  wire logic     clk,
  input  wire logic     rst,
  prog_timer_if.slave   bus
);

  // A one-value prescaler still needs a 1-bit register to stay legal.
  localparam int               PSC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(TICK_DIV - 1);
  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;

  logic             w_step;
  logic             w_wrap;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_next;

  assign w_step = (state_q == S_RUN) && bus.en && (psc_q == PSC_MAX);
  assign w_term = dir_q ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
  // Only periodic mode wraps; one-shot stepping from terminal (possible
  // after a load) is an ordinary +/-1 step.
  assign w_wrap = (cnt_q == w_term) && !mode_q;
  assign w_next = w_wrap ? (dir_q ? reload_q : {WIDTH{1'b0}})
                         : (dir_q ? cnt_q - CNT_ONE : cnt_q + CNT_ONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    psc_d    = psc_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    tc_d     = 1'b0;

    if (bus.stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      psc_d   = '0;
    end else if (bus.start && !bus.stop && (state_q != S_RUN)) begin
      state_d = S_RUN;
      dir_d   = bus.dir;
      mode_d  = bus.mode;
      psc_d   = '0;
    end else if (w_step && !bus.load) begin
      // A coincident load discards the step entirely, including DONE entry.
      psc_d  = '0;
      cnt_d  = w_next;
      tick_d = 1'b1;
      if ((w_next == w_term) && !w_wrap) begin
        tc_d = 1'b1;
        if (mode_q) begin
          state_d = S_DONE;
        end
      end
    end else if ((state_q == S_RUN) && bus.en) begin
      psc_d = psc_q + PSC_ONE;
    end

    // Load leaves the FSM alone but overrides count and prescaler.
    if (bus.load) begin
      cnt_d    = bus.load_val;
      reload_d = bus.load_val;
      psc_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      psc_q    <= '0;
      dir_q    <= 1'b0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      psc_q    <= psc_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.tick = tick_q;
  assign bus.tc   = tc_q;
  assign bus.busy = (state_q == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_prog_timer.sv
// ----------------------------------------------------------------------------
// Module      : tb_prog_timer
// Description : Directed self-checking bench for prog_timer. Instance a uses
//               TICK_DIV=4, WIDTH=4; instance b uses TICK_DIV=1, WIDTH=4.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_prog_timer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  prog_timer_if #(.WIDTH(4)) ifa ();
  prog_timer_if #(.WIDTH(4)) ifb ();

  prog_timer #(.TICK_DIV(4), .WIDTH(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  prog_timer #(.TICK_DIV(1), .WIDTH(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input int c, input bit t, input bit tcv, input bit b);
    check({tag, ".cnt"},  {28'd0, ifa.cnt}, 32'(c));
    check({tag, ".tick"}, {31'd0, ifa.tick}, {31'd0, t});
    check({tag, ".tc"},   {31'd0, ifa.tc},   {31'd0, tcv});
    check({tag, ".busy"}, {31'd0, ifa.busy}, {31'd0, b});
  endtask

  initial begin
    int seq [6];
    seq = '{1, 0, 2, 1, 0, 2};
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    ifa.en = 1'b0; ifa.start = 1'b0; ifa.stop = 1'b0; ifa.load = 1'b0;
    ifa.load_val = 4'd0; ifa.dir = 1'b0; ifa.mode = 1'b0;
    ifb.en = 1'b0; ifb.start = 1'b0; ifb.stop = 1'b0; ifb.load = 1'b0;
    ifb.load_val = 4'd0; ifb.dir = 1'b0; ifb.mode = 1'b0;

    #2;
    check_a("reset", 0, 0, 0, 0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    check_a("idle_after_reset", 0, 0, 0, 0);

    // Up periodic from 0
    ifa.en = 1'b1; ifa.dir = 1'b0; ifa.mode = 1'b0; ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    check_a("up_start", 0, 0, 0, 1);
    for (int k = 1; k <= 15; k++) begin
      cyc(3);
      check("up_pre_tick", {31'd0, ifa.tick}, 32'd0);
      cyc(1);
      check_a($sformatf("up_step%0d", k), k, 1, (k == 15), 1);
    end
    cyc(4);
    check_a("up_wrap", 0, 1, 0, 1);

    // Reset mid-run at cnt=7, asynchronous
    cyc(28);
    check_a("pre_reset_run", 7, 1, 0, 1);
    rst = 1'b1;
    #1;
    check_a("async_reset", 0, 0, 0, 0);
    cyc(1);
    rst = 1'b0;
    cyc(5);
    check_a("idle_post_reset", 0, 0, 0, 0);

    // Down one-shot from 3
    ifa.load_val = 4'd3; ifa.load = 1'b1;
    cyc(1);
    ifa.load = 1'b0;
    check_a("load3", 3, 0, 0, 0);
    ifa.dir = 1'b1; ifa.mode = 1'b1; ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    check_a("dn1_start", 3, 0, 0, 1);
    cyc(4); check_a("dn1_s1", 2, 1, 0, 1);
    cyc(4); check_a("dn1_s2", 1, 1, 0, 1);
    cyc(4); check_a("dn1_s3", 0, 1, 1, 0);
    cyc(8); check_a("dn1_done_hold", 0, 0, 0, 0);

    // Down periodic from 2, started from DONE
    ifa.load_val = 4'd2; ifa.load = 1'b1;
    cyc(1);
    ifa.load = 1'b0;
    check_a("load2", 2, 0, 0, 0);
    ifa.dir = 1'b1; ifa.mode = 1'b0; ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(4);
      check_a($sformatf("dnp_s%0d", k + 1), seq[k], 1, (seq[k] == 0), 1);
    end

    // Pause with prescaler at 2
    cyc(2);
    ifa.en = 1'b0;
    cyc(10);
    check_a("pause_hold", 2, 0, 0, 1);
    ifa.en = 1'b1;
    cyc(1);
    check_a("resume_1", 2, 0, 0, 1);
    cyc(1);
    check_a("resume_2", 1, 1, 0, 1);

    // Load on a step cycle
    cyc(3);
    ifa.load_val = 4'd9; ifa.load = 1'b1;
    cyc(1);
    ifa.load = 1'b0;
    check_a("collide_load", 9, 0, 0, 1);
    cyc(3);
    check_a("collide_wait", 9, 0, 0, 1);
    cyc(1);
    check_a("collide_step", 8, 1, 0, 1);

    // Stop from RUN: count holds
    ifa.stop = 1'b1;
    cyc(1);
    ifa.stop = 1'b0;
    check_a("stop", 8, 0, 0, 0);
    cyc(8);
    check_a("stop_hold", 8, 0, 0, 0);

    // Load with start: run begins from load_val
    ifa.load_val = 4'd5; ifa.load = 1'b1; ifa.start = 1'b1;
    ifa.dir = 1'b0; ifa.mode = 1'b1;
    cyc(1);
    ifa.load = 1'b0; ifa.start = 1'b0;
    check_a("load_start", 5, 0, 0, 1);
    cyc(4);
    check_a("load_start_s1", 6, 1, 0, 1);
    ifa.stop = 1'b1;
    cyc(1);
    ifa.stop = 1'b0;

    // One-shot step from terminal after load is a normal step
    ifa.load_val = 4'd15; ifa.load = 1'b1; ifa.start = 1'b1;
    ifa.dir = 1'b0; ifa.mode = 1'b1;
    cyc(1);
    ifa.load = 1'b0; ifa.start = 1'b0;
    check_a("term_load", 15, 0, 0, 1);
    cyc(4);
    check_a("term_step", 0, 1, 0, 1);
    ifa.stop = 1'b1;
    cyc(1);
    ifa.stop = 1'b0;

    // TICK_DIV=1: steps every enabled cycle
    ifb.en = 1'b1; ifb.dir = 1'b0; ifb.mode = 1'b0; ifb.start = 1'b1;
    cyc(1);
    ifb.start = 1'b0;
    check("div1_start_busy", {31'd0, ifb.busy}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      check($sformatf("div1_cnt%0d", k), {28'd0, ifb.cnt}, 32'(k));
      check($sformatf("div1_tick%0d", k), {31'd0, ifb.tick}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
